// File: rtl/serial_pkg.sv
// Shared definitions for the serial datapath: FSM encodings and the default frame width.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } serial_state_t;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/serial_bit_counter.sv
// Data-bit counter for one frame: clear dominates increment, tc flags the last data bit.
module serial_bit_counter #(
  parameter int WIDTH = serial_pkg::DEF_WIDTH,
  parameter int CNT_W = serial_pkg::DEF_CNT_W
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (inc)  count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/serial_word_capture.sv
// Start-bit framed LSB-first serial-to-parallel capture with a one-cycle valid strobe.
// Define SERIAL_CAPTURE_PARITY_EN to add a trailing even-parity bit and parity_err strobe.
module serial_word_capture
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             parity_err
);

  serial_state_t    state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nxt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_inc;

  assign shreg_nxt = {serial_in, shreg[WIDTH-1:1]};

  // Counter only runs while shifting; any other state (or abort) pins it at zero.
  assign cnt_inc = enable && (state == ST_SHIFT);
  assign cnt_clr = !cnt_inc || tc;

  serial_bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .tc      (tc)
  );

`ifdef SERIAL_CAPTURE_PARITY_EN
  logic perr;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      perr     <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
`ifdef SERIAL_CAPTURE_PARITY_EN
      perr  <= 1'b0;
`endif
      if (!enable) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (serial_in) begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            shreg <= shreg_nxt;
            if (tc) begin
`ifdef SERIAL_CAPTURE_PARITY_EN
              state    <= ST_PARITY;
`else
              data_out <= shreg_nxt;
              valid    <= 1'b1;
              state    <= ST_IDLE;
              busy     <= 1'b0;
`endif
            end
          end
`ifdef SERIAL_CAPTURE_PARITY_EN
          ST_PARITY: begin
            // Word is delivered even on a parity error; the strobe just flags it.
            data_out <= shreg;
            valid    <= 1'b1;
            perr     <= (^shreg) ^ serial_in;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
`endif
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
